// File: rtl/pc_if.sv
// Fetch-side bus of the program counter: D-stage redirect inputs from the pipeline, F-stage PC outputs back to it.
// There is no backpressure: d_valid qualifies the D-stage fields, and stall is the only way to hold the PC.
interface pc_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             d_valid;
  logic [WIDTH-1:0] d_pc4;
  logic [25:0]      d_imm26;
  logic [1:0]       nsel;
  logic [2:0]       br_op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             exc_req;
  logic             eret;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc4;
  logic             taken;
  logic             fetch_err;
  logic [CNT_W-1:0] redir_cnt;

  modport master (
    output stall, d_valid, d_pc4, d_imm26, nsel, br_op, rs_val, rt_val, exc_req, eret, epc,
    input  pc, pc4, taken, fetch_err, redir_cnt
  );

  modport slave (
    input  stall, d_valid, d_pc4, d_imm26, nsel, br_op, rs_val, rt_val, exc_req, eret, epc,
    output pc, pc4, taken, fetch_err, redir_cnt
  );
endinterface

// File: rtl/pc_unit.sv
// F-stage program counter with D-stage next-PC selection (branch/jump/jr with delay slot),
// exception vector, ERET return, stall hold, fetch-window check and saturating redirect counter.
module pc_unit #(
  parameter int                  WIDTH      = 32,
  parameter logic [WIDTH-1:0]    RESET_PC   = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0]    EXC_VECTOR = WIDTH'(32'h0000_4180),
  parameter logic [WIDTH-1:0]    IMEM_BASE  = WIDTH'(32'h0000_3000),
  parameter int unsigned         IMEM_BYTES = 4096,
  parameter int                  CNT_W      = 16
) (
  input logic clk,
  input logic reset,
  pc_if.slave bus
);

  localparam logic [1:0] NSEL_SEQ = 2'd0;
  localparam logic [1:0] NSEL_BR  = 2'd1;
  localparam logic [1:0] NSEL_J   = 2'd2;
  localparam logic [1:0] NSEL_JR  = 2'd3;

  // One extra bit so the exclusive upper bound cannot wrap at the top of the address space.
  localparam logic [WIDTH:0] WIN_LO = {1'b0, IMEM_BASE};
  localparam logic [WIDTH:0] WIN_HI = WIN_LO + (WIDTH+1)'(IMEM_BYTES);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             redirect_load;

  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] sel_target;
  logic             rs_neg;
  logic             rs_zero;
  logic             br_cond;
  logic             taken_c;

  assign br_target = bus.d_pc4 + {{(WIDTH-18){bus.d_imm26[15]}}, bus.d_imm26[15:0], 2'b00};
  assign j_target  = {bus.d_pc4[WIDTH-1:28], bus.d_imm26, 2'b00};

  assign rs_neg  = bus.rs_val[WIDTH-1];
  assign rs_zero = (bus.rs_val == '0);

  always_comb begin
    br_cond = 1'b0;
    case (bus.br_op)
      3'd0:    br_cond = (bus.rs_val == bus.rt_val);
      3'd1:    br_cond = (bus.rs_val != bus.rt_val);
      3'd2:    br_cond = rs_neg | rs_zero;
      3'd3:    br_cond = ~rs_neg & ~rs_zero;
      3'd4:    br_cond = rs_neg;
      3'd5:    br_cond = ~rs_neg;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    taken_c    = 1'b0;
    sel_target = br_target;
    case (bus.nsel)
      NSEL_SEQ: taken_c = 1'b0;
      NSEL_BR:  taken_c = br_cond;
      NSEL_J: begin
        taken_c    = 1'b1;
        sel_target = j_target;
      end
      NSEL_JR: begin
        taken_c    = 1'b1;
        sel_target = bus.rs_val;
      end
      default:  taken_c = 1'b0;
    endcase
    taken_c = taken_c & bus.d_valid;
  end

  // Exception entry and return bypass stall; the delay slot is already fetched, so a redirect never squashes.
  always_comb begin
    pc_d          = pc_q + WIDTH'(4);
    redirect_load = 1'b0;
    if (bus.exc_req) begin
      pc_d = EXC_VECTOR;
    end else if (bus.eret) begin
      pc_d = bus.epc;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (taken_c) begin
      pc_d          = sel_target;
      redirect_load = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (redirect_load && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc4       = pc_q + WIDTH'(4);
  assign bus.taken     = taken_c;
  assign bus.redir_cnt = cnt_q;
  assign bus.fetch_err = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} < WIN_LO) || ({1'b0, pc_q} >= WIN_HI);

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic against a behavioural next-PC model,
// with a second instance at CNT_W=2 to exercise counter saturation.
module tb_pc_unit;

  logic clk;
  logic reset;

  pc_if #(.WIDTH(32), .CNT_W(16)) bus ();
  pc_if #(.WIDTH(32), .CNT_W(2))  bus2 ();

  pc_unit #(.CNT_W(16)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  pc_unit #(.CNT_W(2))  u_sat (.clk(clk), .reset(reset), .bus(bus2));

  assign bus2.stall   = bus.stall;
  assign bus2.d_valid = bus.d_valid;
  assign bus2.d_pc4   = bus.d_pc4;
  assign bus2.d_imm26 = bus.d_imm26;
  assign bus2.nsel    = bus.nsel;
  assign bus2.br_op   = bus.br_op;
  assign bus2.rs_val  = bus.rs_val;
  assign bus2.rt_val  = bus.rt_val;
  assign bus2.exc_req = bus.exc_req;
  assign bus2.eret    = bus.eret;
  assign bus2.epc     = bus.epc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: architectural PC and an unbounded count of accepted redirects.
  logic [31:0] m_pc;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_taken();
    int s;
    s = int'(bus.rs_val);
    if (!bus.d_valid) return 1'b0;
    if (bus.nsel == 2'd0) return 1'b0;
    if (bus.nsel != 2'd1) return 1'b1;
    case (bus.br_op)
      3'd0:    return bus.rs_val == bus.rt_val;
      3'd1:    return bus.rs_val != bus.rt_val;
      3'd2:    return s <= 0;
      3'd3:    return s > 0;
      3'd4:    return s < 0;
      3'd5:    return s >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target();
    int off;
    off = int'(shortint'(bus.d_imm26[15:0])) * 4;
    case (bus.nsel)
      2'd1:    return bus.d_pc4 + 32'(off);
      2'd2:    return {bus.d_pc4[31:28], bus.d_imm26, 2'b00};
      default: return bus.rs_val;
    endcase
  endfunction

  function automatic logic m_fetch_err(input logic [31:0] p);
    longint unsigned a;
    a = longint'(p);
    return (a % 4 != 0) || (a < 64'h3000) || (a >= 64'h3000 + 4096);
  endfunction

  function automatic logic [31:0] sat(input int n, input int maxv);
    return (n > maxv) ? 32'(maxv) : 32'(n);
  endfunction

  task automatic check_outputs();
    chk("pc", bus.pc, m_pc);
    chk("pc4", bus.pc4, m_pc + 32'd4);
    chk("fetch_err", 32'(bus.fetch_err), 32'(m_fetch_err(m_pc)));
    chk("taken", 32'(bus.taken), 32'(m_taken()));
    chk("redir_cnt", 32'(bus.redir_cnt), sat(m_cnt, 65535));
    chk("redir_cnt_sat", 32'(bus2.redir_cnt), sat(m_cnt, 3));
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic cycle();
    logic [31:0] nxt;
    logic        tk;
    #1;
    check_outputs();
    tk  = m_taken();
    nxt = m_target();
    @(posedge clk);
    if (bus.exc_req)    m_pc = 32'h4180;
    else if (bus.eret)  m_pc = bus.epc;
    else if (bus.stall) m_pc = m_pc;
    else if (tk) begin
      m_pc = nxt;
      m_cnt++;
    end else            m_pc = m_pc + 32'd4;
    #1;
  endtask

  task automatic reset_pulse();
    #2 reset = 1'b1;
    #1;
    m_pc  = 32'h3000;
    m_cnt = 0;
    check_outputs();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.stall   = 1'b0;
    bus.d_valid = 1'b0;
    bus.d_pc4   = 32'h0;
    bus.d_imm26 = 26'h0;
    bus.nsel    = 2'd0;
    bus.br_op   = 3'd0;
    bus.rs_val  = 32'h0;
    bus.rt_val  = 32'h0;
    bus.exc_req = 1'b0;
    bus.eret    = 1'b0;
    bus.epc     = 32'h0;
  endtask

  task automatic set_branch(input logic [1:0] nsel, input logic [2:0] op, input logic [31:0] pc4v,
                            input logic [25:0] imm, input logic [31:0] rs, input logic [31:0] rt);
    idle_inputs();
    bus.d_valid = 1'b1;
    bus.nsel    = nsel;
    bus.br_op   = op;
    bus.d_pc4   = pc4v;
    bus.d_imm26 = imm;
    bus.rs_val  = rs;
    bus.rt_val  = rt;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom;
      default: return 32'h3000 + 32'($urandom_range(0, 1023)) * 4;
    endcase
  endfunction

  initial begin
    idle_inputs();
    reset = 1'b1;
    m_pc  = 32'h3000;
    m_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_pc", bus.pc, 32'h3000);
    chk("reset_pc4", bus.pc4, 32'h3004);
    chk("reset_cnt", 32'(bus.redir_cnt), 32'd0);
    chk("reset_err", 32'(bus.fetch_err), 32'd0);

    // Async reset from 0x3010, then three sequential edges.
    repeat (4) cycle();
    chk("seq_0x3010", bus.pc, 32'h3010);
    reset_pulse();
    chk("async_reset_pc", bus.pc, 32'h3000);
    repeat (3) cycle();
    chk("post_reset_pc", bus.pc, 32'h300C);
    chk("post_reset_cnt", 32'(bus.redir_cnt), 32'd0);

    // beq with equal operands, negative offset.
    set_branch(2'd1, 3'd0, 32'h3008, 26'h000FFFE, 32'd5, 32'd5);
    #1 chk("beq_taken", 32'(bus.taken), 32'd1);
    cycle();
    chk("beq_pc", bus.pc, 32'h3000);
    chk("beq_cnt", 32'(bus.redir_cnt), 32'd1);

    // bgtz/bltz on the most negative value.
    set_branch(2'd1, 3'd3, 32'h3008, 26'h0000010, 32'h8000_0000, 32'h0);
    #1 chk("bgtz_taken", 32'(bus.taken), 32'd0);
    cycle();
    chk("bgtz_pc", bus.pc, 32'h3004);
    set_branch(2'd1, 3'd4, 32'h3008, 26'h0000010, 32'h8000_0000, 32'h0);
    #1 chk("bltz_taken", 32'(bus.taken), 32'd1);
    cycle();
    chk("bltz_pc", bus.pc, 32'h3048);

    // JR to misaligned, window end, and last legal word.
    set_branch(2'd3, 3'd0, 32'h3000, 26'h0, 32'h3002, 32'h0);
    cycle();
    chk("jr_misaligned_pc", bus.pc, 32'h3002);
    chk("jr_misaligned_err", 32'(bus.fetch_err), 32'd1);
    set_branch(2'd3, 3'd0, 32'h3000, 26'h0, 32'h4000, 32'h0);
    cycle();
    chk("jr_win_end_err", 32'(bus.fetch_err), 32'd1);
    set_branch(2'd3, 3'd0, 32'h3000, 26'h0, 32'h3FFC, 32'h0);
    cycle();
    chk("jr_last_word_err", 32'(bus.fetch_err), 32'd0);
    chk("cnt_five", 32'(bus.redir_cnt), 32'd5);
    chk("cnt2_saturated", 32'(bus2.redir_cnt), 32'd3);

    // Stall over a taken jump, then stall with exception.
    set_branch(2'd2, 3'd0, 32'h3000, 26'h0000C40, 32'h0, 32'h0);
    bus.stall = 1'b1;
    cycle();
    chk("stall_hold_pc", bus.pc, 32'h3FFC);
    chk("stall_cnt", 32'(bus.redir_cnt), 32'd5);
    bus.exc_req = 1'b1;
    cycle();
    chk("stall_exc_pc", bus.pc, 32'h4180);

    // exc_req and eret together, then eret alone.
    idle_inputs();
    bus.exc_req = 1'b1;
    bus.eret    = 1'b1;
    bus.epc     = 32'h3020;
    cycle();
    chk("exc_eret_pc", bus.pc, 32'h4180);
    bus.exc_req = 1'b0;
    cycle();
    chk("eret_pc", bus.pc, 32'h3020);
    chk("eret_cnt", 32'(bus.redir_cnt), 32'd5);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      idle_inputs();
      bus.d_valid = ($urandom_range(0, 3) != 0);
      bus.nsel    = 2'($urandom_range(0, 3));
      bus.br_op   = 3'($urandom_range(0, 7));
      bus.d_pc4   = 32'h3000 + 32'($urandom_range(0, 1023)) * 4;
      bus.d_imm26 = 26'($urandom);
      bus.rt_val  = pick_val();
      bus.rs_val  = ($urandom_range(0, 2) == 0) ? bus.rt_val : pick_val();
      bus.stall   = ($urandom_range(0, 4) == 0);
      bus.exc_req = ($urandom_range(0, 19) == 0);
      bus.eret    = ($urandom_range(0, 19) == 0);
      bus.epc     = pick_val();
      if ($urandom_range(0, 59) == 0) reset_pulse();
      else                            cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
